ropuf_measure_sequencer: RTL
============================

# ropuf_measure_sequencer

Drives one complete 16-bit RO-PUF response measurement and acts as the producing end of the `round`/`count`/`In` interface that the 16-bit response capture register consumes. For each of 16 rounds it enables one ring-oscillator pair, counts that pair's tick pulses over a fixed 250-cycle window and resolves one response bit. It presents `round`, `count` and the bit with the exact timing the capture register samples: the bit is captured at `count == 250`, and the register clears at `round == 0 && count == 0`. It sits between the RO array with its edge detectors and the response capture register.

## Interface
- `SETTLE_CYC`, default 16, cycles that the RO pair runs before each measurement window (1..255).
- `clk`  in  1  single system clock.
- `Reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a measurement; accepted only in IDLE.
- `ro_a_tick`  in  1  one-cycle pulse per edge of RO A of the selected pair; already synchronized to `clk`.
- `ro_b_tick`  in  1  one-cycle pulse per edge of RO B of the selected pair; already synchronized to `clk`.
- `ro_sel`  out  4  selects the RO pair; equals `round` while busy.
- `ro_en`  out  1  enables the selected RO pair.
- `round`  out  4  to the capture register (bit order [0:3]).
- `count`  out  8  to the capture register (bit order [0:7]).
- `bit_out`  out  1  response bit; drives the capture register's `In`.
- `busy`  out  1  high from `start` acceptance until DONE.
- `done`  out  1  one-cycle pulse when the 16th bit has been presented.

## Operation
- States and what each one does:
  - IDLE: waits for `start`.
  - SETTLE: runs the RO pair before measuring.
  - MEASURE: counts ticks over the window.
  - RESOLVE: presents the round's bit.
  - DONE: signals completion.
- Transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → MEASURE after `SETTLE_CYC` cycles.
  - MEASURE → RESOLVE after 250 cycles.
  - RESOLVE → SETTLE (round+1) if `round` < 15, else → DONE.
  - DONE → IDLE unconditionally.
- SETTLE:
  - `ro_en` = 1, `count` = 0.
  - Both tick counters are cleared on entry.
  - Ticks arriving in SETTLE are ignored.
- MEASURE:
  - `count` steps 0,1,…,249, one per cycle.
  - Each tick pulse increments its 8-bit counter; at most 250 ticks per window, so the counters never overflow.
- RESOLVE:
  - Lasts exactly one cycle, with `count` = 250.
  - `bit_out` = 1 iff A ticks > B ticks, counting all 250 MEASURE cycles including count 249. A tie gives 0.
  - `bit_out` is registered on entry to RESOLVE and held until the next RESOLVE.
- DONE and IDLE after a completed run:
  - `round` = 15, `count` = 255, `ro_en` = 0.
  - These values must never present `round == 0 && count == 0`, so the captured response is retained.
- `start` while `busy` or in DONE is ignored.
- Round 0: `count` = 0 during SETTLE clears the capture register, so every run starts from a clean response.

## Timing
- Values after reset: `round` 0, `count` 0, `bit_out` 0, `ro_sel` 0, `ro_en` 0, `busy` 0, `done` 0, state IDLE. The reset values deliberately clear the downstream register.
- `start` sampled high in IDLE at edge N: SETTLE begins at N+1, with `busy` = 1 and `ro_en` = 1.
- Each round lasts `SETTLE_CYC` + 251 cycles.
- `done` is high for exactly one cycle, 16×(`SETTLE_CYC`+251) cycles after the start-acceptance edge. `busy` falls in the same cycle.
- `round` changes only on RESOLVE exit.
- `count` = 250 occurs exactly once per round, so the capture register writes each bit exactly once.
- `Reset_n` low mid-run: all outputs return to their reset values on the next edge. Tick counts and the partial response are abandoned.
- `Reset_n` has priority over `start` in the same cycle.

## Structure
- Shared package `ropuf_pkg`: `WINDOW_LAST` = 250, `ROUNDS` = 16, `IDLE_COUNT` = 255, and the state enum.
- Sub-module `ro_tick_counter`: 8-bit counter with synchronous clear and tick enable, instantiated twice (A and B).
- The comparator and FSM stay in the top level.

## Test plan
- Reset: hold `Reset_n` = 0 for 3 cycles → `round` 0, `count` 0, `bit_out` 0, `ro_en` 0, `busy` 0, `done` 0.
- `SETTLE_CYC` = 4; A ticks every cycle, B never → `bit_out` = 1 in all 16 RESOLVE cycles; the bench-model register reads 16'hFFFF; `done` arrives at 16×255 cycles; afterwards `round` = 15, `count` = 255.
- A and B both tick every cycle → every bit is 0 (tie); the register reads 16'h0000.
- Per round, even rounds give A 100 ticks vs B 99, odd rounds give A 99 vs B 100 → register reads 16'hAAAA in bit order [0:15].
- A ticks only during SETTLE, B ticks once at count 249 → `bit_out` = 0. Check that the count-249 tick is included.
- Assert `start` again while `busy` → ignored. Drop `Reset_n` during round 7 → next edge shows `round` 0, `count` 0, `busy` 0. A new `start` completes a full 16-round run normally.

Source files
------------

// File: rtl/ropuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ropuf_pkg
// Description : Shared constants and state encoding for the RO-PUF
//               measurement sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ropuf_pkg;

  // Count value that presents the resolved bit to the capture register.
  localparam logic [7:0] WINDOW_LAST = 8'd250;
  // Number of response bits per measurement.
  localparam int         ROUNDS      = 16;
  // Count value parked on after a completed run; never aliases count 0.
  localparam logic [7:0] IDLE_COUNT  = 8'd255;
  localparam logic [3:0] LAST_ROUND  = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ro_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : ro_tick_counter
// Description : 8-bit tick counter with synchronous clear and tick enable.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_tick_counter (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       tick,
  output logic [7:0] value
);

  logic [7:0] r_value;

  // Clear dominates; a tick only counts while the window is open.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (en && tick) begin
      r_value <= r_value + 8'd1;
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/ropuf_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ropuf_measure_sequencer
// Description : Sequences 16 RO-pair measurements and presents round/count/bit
//               with the timing the response capture register samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ropuf_measure_sequencer
  import ropuf_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       ro_a_tick,
  input  logic       ro_b_tick,
  output logic [3:0] ro_sel,
  output logic       ro_en,
  output logic [0:3] round,
  output logic [0:7] count,
  output logic       bit_out,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYC - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_round;
  logic [7:0] r_count;
  logic [7:0] r_settle;
  logic       r_bit;

  logic       w_settle_end;
  logic       w_window_end;
  logic       w_clr;
  logic       w_en;
  logic [7:0] w_a_val;
  logic [7:0] w_b_val;
  logic [8:0] w_a_total;
  logic [8:0] w_b_total;

  ro_tick_counter u_cnt_a (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clr     (w_clr),
    .en      (w_en),
    .tick    (ro_a_tick),
    .value   (w_a_val)
  );

  ro_tick_counter u_cnt_b (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clr     (w_clr),
    .en      (w_en),
    .tick    (ro_b_tick),
    .value   (w_b_val)
  );

  assign w_settle_end = (r_settle == c_settle_last);
  assign w_window_end = (r_count == WINDOW_LAST - 8'd1);

  // The bit is latched on the same edge that counts the final-cycle tick,
  // so fold the in-flight tick into the comparison.
  assign w_a_total = {1'b0, w_a_val} + {8'd0, ro_a_tick};
  assign w_b_total = {1'b0, w_b_val} + {8'd0, ro_b_tick};

  // State register.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded controls.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    ro_en        = 1'b0;
    done         = 1'b0;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy  = 1'b1;
        ro_en = 1'b1;
        w_clr = 1'b1;
        if (w_settle_end) w_state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        busy  = 1'b1;
        ro_en = 1'b1;
        w_en  = 1'b1;
        if (w_window_end) w_state_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        busy  = 1'b1;
        ro_en = 1'b1;
        w_state_next = (r_round == LAST_ROUND) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Round, count, settle timer and response bit; count is the presented value.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_round  <= '0;
      r_count  <= '0;
      r_settle <= '0;
      r_bit    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_round  <= '0;
            r_count  <= '0;
            r_settle <= '0;
          end
        end
        ST_SETTLE: begin
          r_settle <= r_settle + 8'd1;
        end
        ST_MEASURE: begin
          if (w_window_end) begin
            r_count <= WINDOW_LAST;
            r_bit   <= (w_a_total > w_b_total);
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_RESOLVE: begin
          if (r_round == LAST_ROUND) begin
            r_count <= IDLE_COUNT;
          end else begin
            r_round  <= r_round + 4'd1;
            r_count  <= '0;
            r_settle <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign round   = r_round;
  assign count   = r_count;
  assign ro_sel  = r_round;
  assign bit_out = r_bit;

endmodule
`default_nettype wire
